// File: rtl/ravenna_ct_pkg.sv
// Shared definitions for the Ravenna counter/timer: register offsets,
// CONFIG bit positions, bus handshake states and a byte-strobe merge helper.
package ravenna_ct_pkg;

  // Register select values (iomem_addr[3:2])
  localparam logic [1:0] CT_CONFIG = 2'd0;
  localparam logic [1:0] CT_VALUE  = 2'd1;
  localparam logic [1:0] CT_LIMIT  = 2'd2;
  localparam logic [1:0] CT_STATUS = 2'd3;

  // CONFIG bit indices
  localparam int CT_EN      = 0;
  localparam int CT_ONESHOT = 1;
  localparam int CT_UP      = 2;
  localparam int CT_IRQEN   = 3;

  // CONFIG prescale field
  localparam int CT_PRESCALE_LSB = 16;
  localparam int CT_PRESCALE_MSB = 31;

  typedef enum logic [0:0] {
    CT_BUS_IDLE = 1'b0,
    CT_BUS_ACK  = 1'b1
  } ct_bus_state_t;

  // Replace the bytes of old_val selected by wstrb with the matching bytes of wdata.
  function automatic logic [31:0] ct_merge_bytes(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ct_prescaler.sv
// Clock prescaler: counts clk cycles while enabled and emits a one-cycle
// tick every prescale+1 cycles. A clear (CONFIG write) restarts the count
// and suppresses the tick for that cycle.
module ct_prescaler
  import ravenna_ct_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_pcount;

  assign tick = enable && !clear && (r_pcount == prescale);

  // Prescale counter: held at 0 while disabled or cleared, wraps on tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcount <= '0;
    end else if (!enable || clear || tick) begin
      r_pcount <= '0;
    end else begin
      r_pcount <= r_pcount + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ravenna_counter_timer.sv
// Ravenna iomem counter/timer: CONFIG/VALUE/LIMIT/STATUS registers, up/down
// counting on prescaled ticks, one-shot or continuous, level interrupt.
//
// Bus handshake FSM:
//   state       | meaning
//   CT_BUS_IDLE | waiting for iomem_valid; read data captured when it arrives
//   CT_BUS_ACK  | iomem_ready high for one cycle; writes commit at its end
module ravenna_counter_timer
  import ravenna_ct_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [3:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);

  ct_bus_state_t r_bus_state, w_bus_state_nxt;

  logic                      r_enable, r_oneshot, r_up, r_irq_en, r_status, r_irq;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [COUNT_WIDTH-1:0]    r_value, r_limit;
  logic [31:0]               r_rdata;

  logic [1:0]                w_sel;
  logic                      w_commit, w_cfg_wr, w_value_wr, w_limit_wr, w_status_wr;
  logic                      w_tick, w_expiry, w_stop;
  logic [15:0]               w_pre16;
  logic [31:0]               w_cfg_word, w_value_ext, w_limit_ext, w_rd_mux;
  logic [31:0]               w_cfg_merged, w_value_merged, w_limit_merged;
  logic [COUNT_WIDTH-1:0]    w_value_nxt;
  logic                      w_enable_nxt, w_oneshot_nxt, w_up_nxt, w_irq_en_nxt, w_status_nxt;
  logic [PRESCALE_WIDTH-1:0] w_prescale_nxt;
  logic                      w_unused;

  assign iomem_ready = (r_bus_state == CT_BUS_ACK);
  assign iomem_rdata = r_rdata;
  assign irq_out     = r_irq;

  assign w_sel       = iomem_addr[3:2];
  assign w_commit    = (r_bus_state == CT_BUS_ACK) && iomem_valid && (iomem_wstrb != 4'b0000);
  assign w_cfg_wr    = w_commit && (w_sel == CT_CONFIG);
  assign w_value_wr  = w_commit && (w_sel == CT_VALUE);
  assign w_limit_wr  = w_commit && (w_sel == CT_LIMIT);
  assign w_status_wr = w_commit && (w_sel == CT_STATUS);

  assign w_pre16     = 16'(r_prescale);
  assign w_cfg_word  = {w_pre16, 12'b0, r_irq_en, r_up, r_oneshot, r_enable};
  assign w_value_ext = 32'(r_value);
  assign w_limit_ext = 32'(r_limit);

  assign w_cfg_merged   = ct_merge_bytes(w_cfg_word, iomem_wdata, iomem_wstrb);
  assign w_value_merged = ct_merge_bytes(w_value_ext, iomem_wdata, iomem_wstrb);
  assign w_limit_merged = ct_merge_bytes(w_limit_ext, iomem_wdata, iomem_wstrb);

  assign w_unused = ^{iomem_addr[1:0], w_cfg_merged[15:4]};

  ct_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (r_enable),
    .clear    (w_cfg_wr),
    .prescale (r_prescale),
    .tick     (w_tick)
  );

  // Bus handshake state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_bus_state <= CT_BUS_IDLE;
    else       r_bus_state <= w_bus_state_nxt;
  end

  // Bus handshake next state: ack exactly one cycle after valid is seen idle
  always_comb begin
    w_bus_state_nxt = r_bus_state;
    case (r_bus_state)
      CT_BUS_IDLE: if (iomem_valid) w_bus_state_nxt = CT_BUS_ACK;
      CT_BUS_ACK:  w_bus_state_nxt = CT_BUS_IDLE;
      default:     w_bus_state_nxt = CT_BUS_IDLE;
    endcase
  end

  // Read mux over current register state
  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      CT_CONFIG: w_rd_mux = w_cfg_word;
      CT_VALUE:  w_rd_mux = w_value_ext;
      CT_LIMIT:  w_rd_mux = w_limit_ext;
      default:   w_rd_mux = {31'b0, r_status};
    endcase
  end

  // Read data snapshot taken when the request is first sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdata <= '0;
    else if (r_bus_state == CT_BUS_IDLE && iomem_valid) r_rdata <= w_rd_mux;
  end

  // Count step: a VALUE write discards the tick; expiry on 0 (down) or LIMIT (up)
  always_comb begin
    w_value_nxt = r_value;
    w_expiry    = 1'b0;
    w_stop      = 1'b0;
    if (w_value_wr) begin
      w_value_nxt = w_value_merged[COUNT_WIDTH-1:0];
    end else if (w_tick) begin
      if (r_up) begin
        if (r_value == r_limit) begin
          w_expiry = 1'b1;
          if (r_oneshot) w_stop = 1'b1;
          else           w_value_nxt = '0;
        end else begin
          w_value_nxt = r_value + COUNT_WIDTH'(1);
        end
      end else begin
        if (r_value == '0) begin
          w_expiry = 1'b1;
          if (r_oneshot) w_stop = 1'b1;
          else           w_value_nxt = r_limit;
        end else begin
          w_value_nxt = r_value - COUNT_WIDTH'(1);
        end
      end
    end
  end

  // CONFIG and STATUS next values; expiry set beats a same-cycle clear
  always_comb begin
    w_enable_nxt   = r_enable;
    w_oneshot_nxt  = r_oneshot;
    w_up_nxt       = r_up;
    w_irq_en_nxt   = r_irq_en;
    w_prescale_nxt = r_prescale;
    if (w_cfg_wr) begin
      w_enable_nxt   = w_cfg_merged[CT_EN];
      w_oneshot_nxt  = w_cfg_merged[CT_ONESHOT];
      w_up_nxt       = w_cfg_merged[CT_UP];
      w_irq_en_nxt   = w_cfg_merged[CT_IRQEN];
      w_prescale_nxt = w_cfg_merged[CT_PRESCALE_LSB +: PRESCALE_WIDTH];
    end else if (w_stop) begin
      w_enable_nxt = 1'b0;
    end
    w_status_nxt = r_status;
    if (w_status_wr && iomem_wstrb[0] && iomem_wdata[0]) w_status_nxt = 1'b0;
    if (w_expiry) w_status_nxt = 1'b1;
  end

  // Register file update and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_oneshot  <= 1'b0;
      r_up       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_value    <= '0;
      r_limit    <= '0;
      r_status   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_enable   <= w_enable_nxt;
      r_oneshot  <= w_oneshot_nxt;
      r_up       <= w_up_nxt;
      r_irq_en   <= w_irq_en_nxt;
      r_prescale <= w_prescale_nxt;
      r_value    <= w_value_nxt;
      if (w_limit_wr) r_limit <= w_limit_merged[COUNT_WIDTH-1:0];
      r_status   <= w_status_nxt;
      r_irq      <= w_status_nxt & w_irq_en_nxt;
    end
  end

endmodule

// File: tb/tb_ravenna_counter_timer.sv
// Bench for ravenna_counter_timer: directed scenarios with literal
// expectations plus a randomized bus phase, all checked every cycle
// against a register-level behavioural model.
module tb_ravenna_counter_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [3:0]  iomem_addr = 4'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ravenna_counter_timer dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq_out     (irq_out)
  );

  // Behavioural model state
  logic        m_en, m_os, m_up, m_ie, m_st, m_ready, m_irq;
  logic [31:0] m_val, m_lim, m_rdata;
  int          m_pre, m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_os = 0; m_up = 0; m_ie = 0; m_st = 0; m_ready = 0; m_irq = 0;
    m_val = 0; m_lim = 0; m_rdata = 0; m_pre = 0; m_pc = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] cfg_word();
    return (32'(m_pre) << 16) | {28'b0, m_ie, m_up, m_os, m_en};
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] s);
    case (s)
      2'd0:    return cfg_word();
      2'd1:    return m_val;
      2'd2:    return m_lim;
      default: return {31'b0, m_st};
    endcase
  endfunction

  // Advance model and DUT by one clock, then compare outputs
  task automatic cycle();
    logic        v, commit, cfg_wr, val_wr, lim_wr, st_wr, tick, expiry;
    logic [1:0]  s;
    logic [3:0]  ws;
    logic [31:0] wd, c, n_val, n_rdata;
    logic        n_en, n_os, n_up, n_ie, n_st, n_ready;
    int          n_pc, n_pre;
    v = iomem_valid; s = iomem_addr[3:2]; ws = iomem_wstrb; wd = iomem_wdata;
    n_en = m_en; n_os = m_os; n_up = m_up; n_ie = m_ie; n_st = m_st;
    n_val = m_val; n_pre = m_pre; n_rdata = m_rdata; n_ready = 0;
    commit = m_ready && v && (ws != 0);
    if (!m_ready && v) begin n_ready = 1; n_rdata = m_read(s); end
    cfg_wr = commit && s == 2'd0;
    val_wr = commit && s == 2'd1;
    lim_wr = commit && s == 2'd2;
    st_wr  = commit && s == 2'd3;
    tick = m_en && !cfg_wr && (m_pc == m_pre);
    n_pc = (!m_en || cfg_wr || tick) ? 0 : m_pc + 1;
    expiry = 0;
    if (val_wr) n_val = merge(m_val, wd, ws);
    else if (tick) begin
      if (!m_up) begin
        if (m_val == 0) begin expiry = 1; if (m_os) n_en = 0; else n_val = m_lim; end
        else n_val = m_val - 1;
      end else begin
        if (m_val == m_lim) begin expiry = 1; if (m_os) n_en = 0; else n_val = 0; end
        else n_val = m_val + 1;
      end
    end
    if (cfg_wr) begin
      c = merge(cfg_word(), wd, ws);
      n_en = c[0]; n_os = c[1]; n_up = c[2]; n_ie = c[3]; n_pre = int'(c[31:16]);
    end
    if (st_wr && ws[0] && wd[0]) n_st = 0;
    if (expiry) n_st = 1;
    if (lim_wr) m_lim = merge(m_lim, wd, ws);
    @(posedge clk);
    #1;
    m_en = n_en; m_os = n_os; m_up = n_up; m_ie = n_ie; m_st = n_st; m_val = n_val;
    m_pre = n_pre; m_pc = n_pc; m_ready = n_ready; m_rdata = n_rdata; m_irq = n_st & n_ie;
    check("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
    check("irq", {31'b0, irq_out}, {31'b0, m_irq});
    check("value", dut.r_value, m_val);
    check("status", {31'b0, dut.r_status}, {31'b0, m_st});
    if (m_ready) check("rdata", iomem_rdata, m_rdata);
  endtask

  task automatic bus(input logic [3:0] addr, input logic [3:0] strb, input logic [31:0] data,
                     output logic [31:0] rd);
    int waits;
    waits = 0;
    iomem_valid = 1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
    do begin cycle(); waits++; end while (!m_ready && waits < 8);
    rd = iomem_rdata;
    cycle();
    iomem_valid = 0; iomem_wstrb = 0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
    logic [31:0] d;
    bus(addr, strb, data, d);
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(addr, 4'h0, 32'h0, d);
    check(name, d, exp);
  endtask

  initial begin
    logic [31:0] dseq [6];
    logic [3:0]  a, st;
    logic [31:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset in the middle of a read
    wr(4'h4, 32'h55);
    iomem_valid = 1; iomem_addr = 4'h4; iomem_wstrb = 0;
    cycle();
    check("pre_reset_rdata", iomem_rdata, 32'h55);
    #2 reset = 1;
    #1;
    check("reset_ready", {31'b0, iomem_ready}, 32'h0);
    check("reset_rdata", iomem_rdata, 32'h0);
    check("reset_irq", {31'b0, irq_out}, 32'h0);
    iomem_valid = 0;
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    rd_check("rst_config", 4'h0, 32'h0);
    rd_check("rst_value", 4'h4, 32'h0);
    rd_check("rst_limit", 4'h8, 32'h0);
    rd_check("rst_status", 4'hC, 32'h0);

    // Down continuous, prescale 0
    dseq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
    wr(4'h8, 32'd3);
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h9);
    check("down_seq0", dut.r_value, dseq[0]);
    for (int i = 1; i < 6; i++) begin
      cycle();
      check("down_seq", dut.r_value, dseq[i]);
      if (i == 3) check("down_irq_before", {31'b0, irq_out}, 32'h0);
      if (i == 4) check("down_irq_after", {31'b0, irq_out}, 32'h1);
    end
    wr(4'h0, 32'h0);
    rd_check("down_status", 4'hC, 32'h1);
    wr(4'hC, 32'h1);
    rd_check("down_status_clr", 4'hC, 32'h0);

    // One-shot down, prescale 4
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h0004_0003);
    for (int i = 1; i <= 15; i++) begin
      cycle();
      if (i == 4)  check("os_hold", dut.r_value, 32'd2);
      if (i == 5)  check("os_dec1", dut.r_value, 32'd1);
      if (i == 10) check("os_dec0", dut.r_value, 32'd0);
    end
    repeat (4) cycle();
    rd_check("os_config", 4'h0, 32'h0004_0002);
    rd_check("os_value", 4'h4, 32'h0);
    rd_check("os_status", 4'hC, 32'h1);
    wr(4'hC, 32'h1);

    // Up continuous, irq disabled
    wr(4'h8, 32'd5);
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h5);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 5) check("up_top", dut.r_value, 32'd5);
      if (i == 6) begin
        check("up_wrap", dut.r_value, 32'd0);
        check("up_no_irq", {31'b0, irq_out}, 32'h0);
      end
    end
    wr(4'h0, 32'h0);
    rd_check("up_status", 4'hC, 32'h1);
    wr(4'hC, 32'h1);
    rd_check("up_status_clr", 4'hC, 32'h0);

    // VALUE write coincides with a tick
    wr(4'h8, 32'h200);
    wr(4'h0, 32'h1);
    wr(4'h4, 32'h100);
    rd_check("val_wr_wins", 4'h4, 32'h100);
    wr(4'h0, 32'h0);

    // STATUS clear coincides with an expiry
    wr(4'hC, 32'h1);
    wr(4'h4, 32'h0);
    wr(4'h8, 32'h0);
    wr(4'h0, 32'h0001_0007);
    wr(4'hC, 32'h1);
    rd_check("set_wins", 4'hC, 32'h1);
    wr(4'hC, 32'h1);
    rd_check("set_wins_clr", 4'hC, 32'h0);

    // Byte-lane write
    wr(4'h8, 32'h1122_3344);
    wr(4'h8, 32'h00AB_0000, 4'b0100);
    rd_check("byte_lane", 4'h8, 32'h11AB_3344);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        1:       st = 4'hF;
        2:       st = 4'($urandom_range(0, 15));
        default: st = 4'h0;
      endcase
      case (a[3:2])
        2'd0:    d = (32'($urandom_range(0, 3)) << 16) | (32'($urandom) & 32'h0000_FFF0)
                     | 32'($urandom_range(0, 15));
        2'd3:    d = $urandom;
        default: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
      endcase
      bus(a, st, d, d);
      repeat ($urandom_range(0, 4)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
